mem_access_seq: RTL and testbench

- Memory-access sequencer between the microprogrammed control unit and the RAM interface.
- The control unit issues one read or write request: address, size and write data.
- The block drives MOV/RW/size to memory and waits for MFC, with a timeout.
- It captures and zero-extends read data, then returns a single done pulse with an error flag. This replaces ad-hoc MFC wait states in the microcode.

---
 rtl/mem_access_seq.sv | 148 ++++++++++++++
 tb/tb_mem_access_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// Memory-access sequencer: turns one control-unit read/write request into a
// MOV/MFC handshake with the RAM, with alignment checking and a wait timeout.
module mem_access_seq #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_mov,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mfc
);

  // state    | meaning
  // IDLE     | waiting for req; request fields latched on acceptance
  // SETUP    | address/size/rw presented to RAM, mem_mov still low
  // ACCESS   | mem_mov high, waiting for mfc or timeout
  // DONE_OK  | done pulse, err=0
  // DONE_ERR | done pulse, err=1 (illegal request or timeout)
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    ACCESS   = 3'd2,
    DONE_OK  = 3'd3,
    DONE_ERR = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_d;
  logic             mem_rw_d;
  logic [1:0]       mem_size_d;
  logic [31:0]      mem_addr_d;
  logic [31:0]      mem_wdata_d;
  logic             illegal;
  logic [31:0]      wdata_masked;
  logic [31:0]      rdata_ext;

  always_comb begin
    illegal = 1'b0;
    case (size)
      2'b01:   illegal = addr[0];
      2'b10:   illegal = (addr[1:0] != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  always_comb begin
    wdata_masked = wdata;
    case (size)
      2'b00:   wdata_masked = {24'h0, wdata[7:0]};
      2'b01:   wdata_masked = {16'h0, wdata[15:0]};
      default: wdata_masked = wdata;
    endcase
  end

  // Extension follows the latched size, since size may change after acceptance.
  always_comb begin
    rdata_ext = mem_rdata;
    case (mem_size)
      2'b00:   rdata_ext = {24'h0, mem_rdata[7:0]};
      2'b01:   rdata_ext = {16'h0, mem_rdata[15:0]};
      default: rdata_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata;
    mem_rw_d    = mem_rw;
    mem_size_d  = mem_size;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (req) begin
          mem_rw_d    = rw;
          mem_size_d  = size;
          mem_addr_d  = addr;
          mem_wdata_d = wdata_masked;
          state_d     = illegal ? DONE_ERR : SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mfc) begin
          if (mem_rw) rdata_d = rdata_ext;
          state_d = DONE_OK;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE_ERR;
        end
      end
      DONE_OK:  state_d = IDLE;
      DONE_ERR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_mov   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rdata     <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE_OK) || (state_d == DONE_ERR);
      err       <= (state_d == DONE_ERR);
      mem_mov   <= (state_d == ACCESS);
      mem_rw    <= mem_rw_d;
      mem_size  <= mem_size_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: inputs driven and outputs sampled on the
// falling edge; each step() advances exactly one rising edge.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_mov;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mfc;

  int checks   = 0;
  int failures = 0;

  mem_access_seq #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mfc(mfc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic r, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] w);
    req = 1'b1; rw = r; size = s; addr = a; wdata = w;
    step();
    req = 1'b0; rw = ~r; size = 2'b11; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    mem_rdata = '0; mfc = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mov", mem_mov, 0);
    chk("rst_rw", mem_rw, 0);
    chk("rst_size", mem_size, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    step();

    // word read, zero wait
    mem_rdata = 32'hDEAD_BEEF;
    issue(1'b1, 2'b10, 32'h100, 32'h1111_1111);
    chk("w_setup_busy", busy, 1);
    chk("w_setup_mov", mem_mov, 0);
    chk("w_setup_addr", mem_addr, 32'h100);
    chk("w_setup_size", mem_size, 2'b10);
    chk("w_setup_rw", mem_rw, 1);
    step();
    chk("w_acc_mov", mem_mov, 1);
    chk("w_acc_done", done, 0);
    mfc = 1'b1;
    step();
    mfc = 1'b0;
    chk("w_done", done, 1);
    chk("w_err", err, 0);
    chk("w_mov_off", mem_mov, 0);
    chk("w_rdata", rdata, 32'hDEAD_BEEF);
    chk("w_done_busy", busy, 1);
    step();
    chk("w_idle_busy", busy, 0);
    chk("w_idle_done", done, 0);

    // byte read, three wait states
    mem_rdata = 32'h1234_56A5;
    issue(1'b1, 2'b00, 32'h103, 32'h0);
    chk("b_setup_mov", mem_mov, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b_acc_mov", mem_mov, 1);
      chk("b_acc_done", done, 0);
    end
    mfc = 1'b1;
    step();
    mfc = 1'b0;
    chk("b_done", done, 1);
    chk("b_err", err, 0);
    chk("b_mov_off", mem_mov, 0);
    chk("b_rdata", rdata, 32'h0000_00A5);
    step();

    // halfword write
    mem_rdata = 32'hFFFF_FFFF;
    issue(1'b0, 2'b01, 32'h202, 32'hCAFE_BABE);
    chk("h_wdata", mem_wdata, 32'h0000_BABE);
    chk("h_rw", mem_rw, 0);
    chk("h_addr", mem_addr, 32'h202);
    chk("h_size", mem_size, 2'b01);
    step();
    chk("h_acc_mov", mem_mov, 1);
    chk("h_stable_wdata", mem_wdata, 32'h0000_BABE);
    mfc = 1'b1;
    step();
    mfc = 1'b0;
    chk("h_done", done, 1);
    chk("h_err", err, 0);
    chk("h_rdata_kept", rdata, 32'h0000_00A5);
    step();

    // illegal requests: error at N+1, no mem_mov
    issue(1'b1, 2'b10, 32'h102, 32'h0);
    chk("ilw_done", done, 1);
    chk("ilw_err", err, 1);
    chk("ilw_mov", mem_mov, 0);
    step();
    chk("ilw_idle", busy, 0);
    chk("ilw_mov2", mem_mov, 0);
    issue(1'b1, 2'b01, 32'h101, 32'h0);
    chk("ilh_done", done, 1);
    chk("ilh_err", err, 1);
    chk("ilh_mov", mem_mov, 0);
    step();
    issue(1'b0, 2'b11, 32'h100, 32'h0);
    chk("ils_done", done, 1);
    chk("ils_err", err, 1);
    chk("ils_mov", mem_mov, 0);
    chk("ils_rdata", rdata, 32'h0000_00A5);
    step();
    chk("ils_idle_done", done, 0);

    // timeout: 15 ACCESS cycles then error
    mem_rdata = 32'h7777_7777;
    issue(1'b1, 2'b10, 32'h300, 32'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_mov", mem_mov, 1);
      chk("to_no_done", done, 0);
    end
    step();
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_mov_off", mem_mov, 0);
    chk("to_rdata", rdata, 32'h0000_00A5);
    step();

    // mfc on the last allowed cycle wins over timeout
    mem_rdata = 32'hFFFF_FF3C;
    issue(1'b1, 2'b00, 32'h301, 32'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("tl_mov", mem_mov, 1);
    end
    mfc = 1'b1;
    step();
    mfc = 1'b0;
    chk("tl_done", done, 1);
    chk("tl_err", err, 0);
    chk("tl_rdata", rdata, 32'h0000_003C);
    step();

    // reset during ACCESS aborts without done
    issue(1'b0, 2'b10, 32'h500, 32'hABCD_0123);
    step();
    chk("ra_mov", mem_mov, 1);
    rst_n = 1'b0;
    step();
    chk("ra_mov_off", mem_mov, 0);
    chk("ra_busy", busy, 0);
    chk("ra_done", done, 0);
    chk("ra_addr", mem_addr, 0);
    chk("ra_wdata", mem_wdata, 0);
    chk("ra_rdata", rdata, 0);
    rst_n = 1'b1;
    step();
    chk("ra_post_done", done, 0);
    step();
    chk("ra_post_done2", done, 0);

    // held req: second access accepted on the IDLE cycle after done
    mem_rdata = 32'h8765_4321;
    mfc = 1'b1;
    req = 1'b1; rw = 1'b1; size = 2'b10; addr = 32'h400;
    step();
    chk("hr_setup_addr", mem_addr, 32'h400);
    step();
    chk("hr_acc_mov", mem_mov, 1);
    step();
    addr = 32'h404;
    chk("hr_done", done, 1);
    chk("hr_rdata", rdata, 32'h8765_4321);
    chk("hr_addr_held", mem_addr, 32'h400);
    step();
    chk("hr_idle_busy", busy, 0);
    chk("hr_idle_addr", mem_addr, 32'h400);
    step();
    req = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    chk("hr2_busy", busy, 1);
    chk("hr2_addr", mem_addr, 32'h404);
    chk("hr2_mov", mem_mov, 0);
    step();
    chk("hr2_acc_mov", mem_mov, 1);
    step();
    mfc = 1'b0;
    chk("hr2_done", done, 1);
    chk("hr2_rdata", rdata, 32'h0BAD_F00D);
    step();
    chk("hr2_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
